// File: rtl/goldschmidt_ctrl.sv
// goldschmidt_ctrl
//   Sequencer for a shared-multiplier Goldschmidt divide datapath. It takes one
//   N/D operand pair over a valid/ready request port and holds only one divide
//   in flight. For ITERS iterations it drives the datapath selects and the
//   register-load strobes. It then captures the quotient from the datapath
//   result bus and returns it over a valid/ready response port.
//
//   Parameters: WIDTH (operand width, quotient 2*WIDTH), ITERS (>=1),
//               MUL_LAT (multiplier latency in cycles, >=1)
//   Optional feature macro: DIV_ZERO_DETECT_EN
//      defined   - a divisor of zero skips the datapath: resp_q = all ones, divz = 1
//      undefined - divz is tied low and D==0 runs the normal sequence
//
//   Ports
//      clk, reset            clock, synchronous active-high reset
//      req_valid/req_ready   operand request handshake (ready only when idle)
//      req_n, req_d          dividend / divisor
//      resp_valid/resp_ready quotient response handshake
//      resp_q, divz          registered quotient and divide-by-zero flag
//      dp_n, dp_d            captured operands to the datapath
//      dp_result             datapath result bus
//      ndSelect              0 = multiply N path, 1 = multiply D path
//      kSelect               0 = initial approximation, 1 = K register
//      load_sel              1 = N/D registers load dp_n/dp_d, 0 = load product
//      ld_n, ld_d, ld_k      datapath register load strobes
//      busy                  a divide is in progress or awaiting pickup

module goldschmidt_ctrl #(
   parameter int WIDTH   = 16,
   parameter int ITERS   = 3,
   parameter int MUL_LAT = 1
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 req_valid,
   output logic                 req_ready,
   input  logic [WIDTH-1:0]     req_n,
   input  logic [WIDTH-1:0]     req_d,
   output logic                 resp_valid,
   input  logic                 resp_ready,
   output logic [2*WIDTH-1:0]   resp_q,
   output logic [WIDTH-1:0]     dp_n,
   output logic [WIDTH-1:0]     dp_d,
   input  logic [2*WIDTH-1:0]   dp_result,
   output logic                 ndSelect,
   output logic                 kSelect,
   output logic                 load_sel,
   output logic                 ld_n,
   output logic                 ld_d,
   output logic                 ld_k,
   output logic                 busy,
   output logic                 divz
);

   // state | meaning
   // IDLE  | waiting for an operand request, req_ready high
   // LOAD  | N/D registers load the captured operands
   // MULN  | MUL_LAT cycles multiplying the N path, ld_n on the last one
   // MULD  | MUL_LAT cycles multiplying the D path, ld_d on the last one
   // UPDK  | K register loads 2 - D, then next iteration or finish
   // FIN   | capture the datapath result as the quotient
   // DONE  | quotient presented until the consumer takes it

   localparam int IW = $clog2(ITERS + 1);
   localparam int CW = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_LOAD = 3'd1;
   localparam logic [2:0] S_MULN = 3'd2;
   localparam logic [2:0] S_MULD = 3'd3;
   localparam logic [2:0] S_UPDK = 3'd4;
   localparam logic [2:0] S_FIN  = 3'd5;
   localparam logic [2:0] S_DONE = 3'd6;

   logic [2:0]    state;
   logic [2:0]    state_nxt;
   logic [IW-1:0] iter;
   logic [CW-1:0] wcnt;
   logic          last_wait;
   logic          last_iter;
   logic          in_mul;
   logic          zero_div;
   logic          divz_r;

`ifdef DIV_ZERO_DETECT_EN
   assign zero_div = (req_d == '0);
`else
   // Without detection the flag register can never be set and folds to zero.
   assign zero_div = 1'b0;
`endif

   assign in_mul    = (state == S_MULN) || (state == S_MULD);
   assign last_wait = (wcnt == CW'(MUL_LAT - 1));
   assign last_iter = (iter == IW'(ITERS - 1));

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (req_valid) state_nxt = zero_div ? S_DONE : S_LOAD;
         S_LOAD:  state_nxt = S_MULN;
         S_MULN:  if (last_wait) state_nxt = S_MULD;
         S_MULD:  if (last_wait) state_nxt = S_UPDK;
         S_UPDK:  state_nxt = last_iter ? S_FIN : S_MULN;
         S_FIN:   state_nxt = S_DONE;
         S_DONE:  if (resp_ready) state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= S_IDLE;
         iter   <= '0;
         wcnt   <= '0;
         resp_q <= '0;
         dp_n   <= '0;
         dp_d   <= '0;
         divz_r <= 1'b0;
      end else begin
         state <= state_nxt;

         // The wait counter only runs while a multiply state repeats; any
         // state change (including leaving on last_wait) restarts it at 0.
         if (in_mul && !last_wait)
            wcnt <= wcnt + 1'b1;
         else
            wcnt <= '0;

         if (state == S_IDLE && req_valid) begin
            dp_n   <= req_n;
            dp_d   <= req_d;
            iter   <= '0;
            divz_r <= zero_div;
            if (zero_div)
               resp_q <= '1;
         end

         if (state == S_UPDK && !last_iter)
            iter <= iter + 1'b1;

         if (state == S_FIN)
            resp_q <= dp_result;
      end
   end

   assign req_ready  = (state == S_IDLE);
   assign busy       = (state != S_IDLE);
   assign resp_valid = (state == S_DONE);
   assign divz       = divz_r;

   // LOAD is the one cycle where both N and D strobes fire together.
   assign load_sel = (state == S_LOAD);
   assign ld_n     = (state == S_LOAD) || ((state == S_MULN) && last_wait);
   assign ld_d     = (state == S_LOAD) || ((state == S_MULD) && last_wait);
   assign ld_k     = (state == S_UPDK);
   assign ndSelect = (state == S_MULD);
   assign kSelect  = in_mul && (iter != '0);

endmodule
